// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter
//   Round-robin arbiter granting one shared resource to one of N requesters.
//   The grant is registered and held until the owner releases it (done, or
//   dropping its req) or until MAX_HOLD cycles have elapsed.
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   req      in   [N] level request per requester
//   done     in   release strobe from the current owner (ignored in IDLE)
//   gnt      out  [N] registered one-hot grant, zero when no owner
//   busy     out  registered, high exactly when gnt is non-zero
//   any_req  out  combinational OR of req
//   timeout  out  registered one-cycle pulse on forced revocation
module rr_grant_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         done,
    output logic [N-1:0] gnt,
    output logic         busy,
    output logic         any_req,
    output logic         timeout
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;
    localparam logic [PW-1:0] LAST_IDX  = PW'(N - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t         state;
    logic [PW-1:0]  ptr;
    logic [HW-1:0]  hold_cnt;

    logic [PW-1:0]  sel_idx;
    logic [PW-1:0]  hi_idx;
    logic [PW-1:0]  lo_idx;
    logic           hi_found;
    logic [PW-1:0]  ptr_nxt;
    logic           owner_req;

    assign any_req = |req;

    // Scan from the top down so the last hit is the lowest index. lo_idx is
    // the lowest requester overall, which is the wrap-around choice whenever
    // nothing at or above ptr is requesting.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_idx = PW'(i);
                if (i >= int'(ptr)) begin
                    hi_found = 1'b1;
                    hi_idx   = PW'(i);
                end
            end
        end
        sel_idx = hi_found ? hi_idx : lo_idx;
    end

    // Explicit wrap so non-power-of-two N never lands on an unused index.
    assign ptr_nxt = (sel_idx == LAST_IDX) ? '0 : sel_idx + PW'(1);

    // gnt is one-hot while in GRANT, so this picks out req of the owner.
    assign owner_req = |(gnt & req);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt      <= N'(1) << sel_idx;
                        busy     <= 1'b1;
                        ptr      <= ptr_nxt;
                        hold_cnt <= '0;
                        state    <= GRANT;
                    end else begin
                        gnt  <= '0;
                        busy <= 1'b0;
                    end
                end
                GRANT: begin
                    // Voluntary release outranks the timeout on the same edge.
                    if (done || !owner_req) begin
                        gnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (MAX_HOLD != 0 && hold_cnt == HOLD_LAST) begin
                        gnt     <= '0;
                        busy    <= 1'b0;
                        timeout <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed testbench for rr_grant_arbiter (N=4, MAX_HOLD=16).
module tb_rr_grant_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic       done = 1'b0;
    logic [3:0] gnt;
    logic       busy;
    logic       any_req;
    logic       timeout;

    int pass_cnt = 0;
    int total_cnt = 0;

    rr_grant_arbiter #(.N(4), .MAX_HOLD(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .busy    (busy),
        .any_req (any_req),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1ns so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Short reset pulse placed between edges so ptr restarts at 0.
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        req = 4'b0000; done = 1'b0; rst_n = 1'b0;
        #2;
        total_cnt++; if (gnt !== 4'b0000) $display("FAIL reset_gnt got=%b exp=0000", gnt); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
        total_cnt++; if (timeout !== 1'b0) $display("FAIL reset_timeout got=%b exp=0", timeout); else pass_cnt++;
        // any_req is combinational and must follow req while reset is held.
        req = 4'b0101;
        tick();
        total_cnt++; if (any_req !== 1'b1) $display("FAIL reset_any_req got=%b exp=1", any_req); else pass_cnt++;
        total_cnt++; if (gnt !== 4'b0000) $display("FAIL reset_hold_gnt got=%b exp=0000", gnt); else pass_cnt++;
        req = 4'b0000;
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            total_cnt++; if (gnt !== 4'b0000) $display("FAIL idle_gnt cyc=%0d got=%b exp=0000", c, gnt); else pass_cnt++;
            total_cnt++; if (busy !== 1'b0) $display("FAIL idle_busy cyc=%0d got=%b exp=0", c, busy); else pass_cnt++;
            total_cnt++; if (timeout !== 1'b0) $display("FAIL idle_timeout cyc=%0d got=%b exp=0", c, timeout); else pass_cnt++;
            total_cnt++; if (any_req !== 1'b0) $display("FAIL idle_any_req cyc=%0d got=%b exp=0", c, any_req); else pass_cnt++;
        end
    endtask

    task automatic test_rotation();
        logic [3:0] exp_seq [5];
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        req = 4'b1111;
        // done asserted in IDLE must be ignored: grant still issues.
        done = 1'b1;
        tick();
        done = 1'b0;
        total_cnt++; if (gnt !== exp_seq[0]) $display("FAIL rot_done_idle got=%b exp=%b", gnt, exp_seq[0]); else pass_cnt++;
        for (int j = 0; j < 5; j++) begin
            if (j != 0) tick();
            total_cnt++; if (gnt !== exp_seq[j]) $display("FAIL rot_gnt idx=%0d got=%b exp=%b", j, gnt, exp_seq[j]); else pass_cnt++;
            total_cnt++; if (busy !== 1'b1) $display("FAIL rot_busy idx=%0d got=%b exp=1", j, busy); else pass_cnt++;
            done = 1'b1;
            tick();
            done = 1'b0;
            total_cnt++; if (gnt !== 4'b0000) $display("FAIL rot_bubble idx=%0d got=%b exp=0000", j, gnt); else pass_cnt++;
            total_cnt++; if (busy !== 1'b0) $display("FAIL rot_bubble_busy idx=%0d got=%b exp=0", j, busy); else pass_cnt++;
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_req_drop();
        do_reset();
        req = 4'b0100;
        tick();
        total_cnt++; if (gnt !== 4'b0100) $display("FAIL drop_first got=%b exp=0100", gnt); else pass_cnt++;
        req = 4'b1011;
        tick();
        total_cnt++; if (gnt !== 4'b0000) $display("FAIL drop_release got=%b exp=0000", gnt); else pass_cnt++;
        total_cnt++; if (timeout !== 1'b0) $display("FAIL drop_timeout got=%b exp=0", timeout); else pass_cnt++;
        tick();
        total_cnt++; if (gnt !== 4'b1000) $display("FAIL drop_next got=%b exp=1000", gnt); else pass_cnt++;
        // Other requesters toggling must not move an active grant.
        req = 4'b1001;
        tick();
        total_cnt++; if (gnt !== 4'b1000) $display("FAIL drop_hold got=%b exp=1000", gnt); else pass_cnt++;
        req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        req = 4'b0001;
        tick();
        for (int c = 0; c < 16; c++) begin
            if (c != 0) tick();
            total_cnt++; if (gnt !== 4'b0001) $display("FAIL to_hold cyc=%0d got=%b exp=0001", c, gnt); else pass_cnt++;
            total_cnt++; if (timeout !== 1'b0) $display("FAIL to_early cyc=%0d got=%b exp=0", c, timeout); else pass_cnt++;
        end
        tick();
        total_cnt++; if (gnt !== 4'b0000) $display("FAIL to_revoke got=%b exp=0000", gnt); else pass_cnt++;
        total_cnt++; if (timeout !== 1'b1) $display("FAIL to_pulse got=%b exp=1", timeout); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL to_busy got=%b exp=0", busy); else pass_cnt++;
        tick();
        total_cnt++; if (gnt !== 4'b0001) $display("FAIL to_regrant got=%b exp=0001", gnt); else pass_cnt++;
        total_cnt++; if (timeout !== 1'b0) $display("FAIL to_pulse_end got=%b exp=0", timeout); else pass_cnt++;
        req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_release_vs_timeout();
        do_reset();
        req = 4'b0001;
        tick();
        for (int c = 1; c < 16; c++) tick();
        total_cnt++; if (gnt !== 4'b0001) $display("FAIL rvt_pre got=%b exp=0001", gnt); else pass_cnt++;
        done = 1'b1;
        tick();
        done = 1'b0;
        total_cnt++; if (gnt !== 4'b0000) $display("FAIL rvt_gnt got=%b exp=0000", gnt); else pass_cnt++;
        total_cnt++; if (timeout !== 1'b0) $display("FAIL rvt_timeout got=%b exp=0", timeout); else pass_cnt++;
        req = 4'b0000;
        tick();
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req = 4'b1010;
        tick();
        total_cnt++; if (gnt !== 4'b0010) $display("FAIL mid_first got=%b exp=0010", gnt); else pass_cnt++;
        tick();
        rst_n = 1'b0;
        #1;
        total_cnt++; if (gnt !== 4'b0000) $display("FAIL mid_async_gnt got=%b exp=0000", gnt); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL mid_async_busy got=%b exp=0", busy); else pass_cnt++;
        tick();
        total_cnt++; if (gnt !== 4'b0000) $display("FAIL mid_held got=%b exp=0000", gnt); else pass_cnt++;
        rst_n = 1'b1;
        tick();
        total_cnt++; if (gnt !== 4'b0010) $display("FAIL mid_after got=%b exp=0010", gnt); else pass_cnt++;
        req = 4'b0000;
        tick();
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_req_drop();
        test_timeout();
        test_release_vs_timeout();
        test_reset_mid_grant();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
